// File: rtl/prio_mux_pkg.sv
// Shared types and constants for the priority gather mux and its scatter return path.
package prio_mux_pkg;

  localparam int LANE_IDX_W  = 3;
  localparam int LANE_DATA_W = 4;

  localparam bit L2H = 1'b1;
  localparam bit H2L = 1'b0;

  typedef struct packed {
    logic [LANE_IDX_W-1:0]  idx;
    logic [LANE_DATA_W-1:0] data;
  } lane_t;

  // True when lane j wins a collision against lane k for the given direction.
  function automatic logic outranks(input int j, input int k, input bit dir);
    return (dir == L2H) ? (j < k) : (j > k);
  endfunction

endpackage

// File: rtl/scatter_slot.sv
// One-entry holding register with a valid/ready handshake toward its consumer.
module scatter_slot #(
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_ready,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  free
);

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;

  // A write always wins over a drain, so drain+refill keeps valid high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (wr_en) begin
      r_valid <= 1'b1;
      r_data  <= wr_data;
    end else if (rd_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign valid = r_valid;
  assign data  = r_data;
  assign free  = !r_valid || rd_ready;

endmodule

// File: rtl/prio_scatter_n.sv
// Scatters compacted, index-tagged lanes back into per-slot holding registers.
module prio_scatter_n
  import prio_mux_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int SIZE       = $clog2(WIDTH),
  parameter int DATA_WIDTH = 4,
  parameter int NUM_SEL    = 3,
  parameter bit DIR_L2H    = L2H
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_SEL-1:0]            in_valid,
  input  logic [NUM_SEL*SIZE-1:0]       in_idx,
  input  logic [NUM_SEL*DATA_WIDTH-1:0] in_data,
  output logic [NUM_SEL-1:0]            in_ready,
  output logic [WIDTH-1:0]              out_valid,
  output logic [WIDTH*DATA_WIDTH-1:0]   out_data,
  input  logic [WIDTH-1:0]              out_ready,
  output logic                          err_oor
);

  logic [SIZE-1:0]             w_idx [NUM_SEL];
  logic [NUM_SEL-1:0]          w_oor;
  logic [NUM_SEL-1:0]          w_blocked;
  logic [NUM_SEL-1:0]          w_sel_free;
  logic [NUM_SEL-1:0]          w_ready;
  logic [NUM_SEL-1:0]          w_acc;
  logic [WIDTH-1:0]            w_free;
  logic [WIDTH-1:0]            w_wr_en;
  logic [WIDTH*DATA_WIDTH-1:0] w_wr_data;
  logic                        r_err_oor;

  always_comb begin
    for (int k = 0; k < NUM_SEL; k++) begin
      w_idx[k] = in_idx[k*SIZE +: SIZE];
      w_oor[k] = int'(w_idx[k]) >= WIDTH;
    end
  end

  // Readiness never looks at the lane's own valid, only at competitors' valids.
  always_comb begin
    w_blocked  = '0;
    w_sel_free = '0;
    for (int k = 0; k < NUM_SEL; k++) begin
      for (int j = 0; j < NUM_SEL; j++) begin
        if (j != k && outranks(j, k, DIR_L2H) && in_valid[j] && w_idx[j] == w_idx[k])
          w_blocked[k] = 1'b1;
      end
      for (int i = 0; i < WIDTH; i++) begin
        if (w_idx[k] == SIZE'(i))
          w_sel_free[k] = w_free[i];
      end
    end
    w_ready = w_oor | (w_sel_free & ~w_blocked);
    w_acc   = in_valid & w_ready & ~w_oor;
  end

  // The collision rule leaves at most one accepted lane per slot, so an OR-mux suffices.
  always_comb begin
    w_wr_en   = '0;
    w_wr_data = '0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int k = 0; k < NUM_SEL; k++) begin
        if (w_acc[k] && w_idx[k] == SIZE'(i)) begin
          w_wr_en[i] = 1'b1;
          w_wr_data[i*DATA_WIDTH +: DATA_WIDTH] = w_wr_data[i*DATA_WIDTH +: DATA_WIDTH]
                                                | in_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_slot
    scatter_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (w_wr_en[g]),
      .wr_data  (w_wr_data[g*DATA_WIDTH +: DATA_WIDTH]),
      .rd_ready (out_ready[g]),
      .valid    (out_valid[g]),
      .data     (out_data[g*DATA_WIDTH +: DATA_WIDTH]),
      .free     (w_free[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_err_oor <= 1'b0;
    else if (|(in_valid & w_oor))
      r_err_oor <= 1'b1;
  end

  assign in_ready = w_ready;
  assign err_oor  = r_err_oor;

endmodule

// File: tb/tb_prio_scatter_n.sv
// Directed checks of prio_scatter_n: lane-0-priority, lane-2-priority and 6-slot variants.
module tb_prio_scatter_n;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  in_valid;
  logic [8:0]  in_idx;
  logic [11:0] in_data;
  logic [7:0]  out_ready;

  logic [2:0]  l2h_ready;
  logic [7:0]  l2h_valid;
  logic [31:0] l2h_data;
  logic        l2h_err;

  logic [2:0]  h2l_ready;
  logic [7:0]  h2l_valid;
  logic [31:0] h2l_data;
  logic        h2l_err;

  logic [2:0]  w6_in_valid;
  logic [5:0]  w6_out_ready;
  logic [2:0]  w6_ready;
  logic [5:0]  w6_valid;
  logic [23:0] w6_data;
  logic        w6_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  prio_scatter_n #(.WIDTH(8), .DATA_WIDTH(4), .NUM_SEL(3), .DIR_L2H(1'b1)) u_l2h (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_idx(in_idx), .in_data(in_data),
    .in_ready(l2h_ready), .out_valid(l2h_valid), .out_data(l2h_data),
    .out_ready(out_ready), .err_oor(l2h_err));

  prio_scatter_n #(.WIDTH(8), .DATA_WIDTH(4), .NUM_SEL(3), .DIR_L2H(1'b0)) u_h2l (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_idx(in_idx), .in_data(in_data),
    .in_ready(h2l_ready), .out_valid(h2l_valid), .out_data(h2l_data),
    .out_ready(out_ready), .err_oor(h2l_err));

  prio_scatter_n #(.WIDTH(6), .DATA_WIDTH(4), .NUM_SEL(3), .DIR_L2H(1'b1)) u_w6 (
    .clk(clk), .rst_n(rst_n), .in_valid(w6_in_valid), .in_idx(in_idx), .in_data(in_data),
    .in_ready(w6_ready), .out_valid(w6_valid), .out_data(w6_data),
    .out_ready(w6_out_ready), .err_oor(w6_err));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] idx3(input int a0, input int a1, input int a2);
    logic [2:0] i0, i1, i2;
    i0 = a0[2:0];
    i1 = a1[2:0];
    i2 = a2[2:0];
    return {i2, i1, i0};
  endfunction

  initial begin
    rst_n        = 1'b0;
    in_valid     = 3'($urandom);
    in_idx       = 9'($urandom);
    in_data      = 12'($urandom);
    out_ready    = 8'($urandom);
    w6_in_valid  = 3'($urandom);
    w6_out_ready = 6'($urandom);

    // 1: reset with random inputs
    tick();
    chk("rst_valid", 64'(l2h_valid), 64'h0);
    chk("rst_data",  64'(l2h_data),  64'h0);
    chk("rst_err",   64'(l2h_err),   64'h0);
    chk("rst_w6_err", 64'(w6_err),   64'h0);
    in_valid = 3'($urandom);
    tick();
    rst_n = 1'b1;
    in_valid = '0; w6_in_valid = '0; out_ready = '0; w6_out_ready = '0;
    in_idx = '0; in_data = '0;
    tick();
    chk("idle_valid", 64'(l2h_valid), 64'h0);

    // 2: distinct targets, full throughput
    in_valid = 3'b111;
    in_idx   = idx3(3, 5, 0);
    in_data  = {4'hC, 4'hB, 4'hA};
    #1;
    chk("dist_ready", 64'(l2h_ready), 64'h7);
    tick();
    in_valid = '0;
    chk("dist_valid", 64'(l2h_valid), 64'h29);
    chk("dist_slot3", 64'(l2h_data[15:12]), 64'hA);
    chk("dist_slot5", 64'(l2h_data[23:20]), 64'hB);
    chk("dist_slot0", 64'(l2h_data[3:0]),   64'hC);
    out_ready = 8'hFF;
    tick();
    out_ready = '0;
    chk("drain_valid", 64'(l2h_valid), 64'h0);

    // 3: collision on slot 4
    in_valid = 3'b101;
    in_idx   = idx3(4, 0, 4);
    in_data  = {4'h2, 4'h0, 4'h1};
    #1;
    chk("coll_ready_l2h", 64'(l2h_ready), 64'h3);
    chk("coll_ready_h2l", 64'(h2l_ready), 64'h6);
    tick();
    chk("coll_slot4_l2h", 64'(l2h_data[19:16]), 64'h1);
    chk("coll_slot4_h2l", 64'(h2l_data[19:16]), 64'h2);
    chk("coll_valid_l2h", 64'(l2h_valid), 64'h10);
    in_valid     = 3'b100;
    out_ready[4] = 1'b1;
    #1;
    chk("coll_retry_ready", 64'(l2h_ready[2]), 64'h1);
    tick();
    in_valid = '0;
    out_ready = '0;
    chk("coll_slot4_2nd", 64'(l2h_data[19:16]), 64'h2);
    chk("coll_valid_2nd", 64'(l2h_valid[4]), 64'h1);
    out_ready = 8'hFF;
    tick();
    out_ready = '0;

    // 4: backpressure on slot 6, then drain+refill
    in_valid = 3'b010;
    in_idx   = idx3(0, 6, 0);
    in_data  = {4'h0, 4'h9, 4'h0};
    tick();
    in_data  = {4'h0, 4'h5, 4'h0};
    #1;
    chk("bp_ready_stall", 64'(l2h_ready[1]), 64'h0);
    tick();
    chk("bp_slot6_held", 64'(l2h_data[27:24]), 64'h9);
    chk("bp_valid_held", 64'(l2h_valid[6]), 64'h1);
    out_ready[6] = 1'b1;
    #1;
    chk("bp_ready_same_cycle", 64'(l2h_ready[1]), 64'h1);
    tick();
    in_valid  = '0;
    out_ready = '0;
    chk("bp_slot6_new", 64'(l2h_data[27:24]), 64'h5);
    chk("bp_valid_kept", 64'(l2h_valid[6]), 64'h1);
    out_ready = 8'hFF;
    tick();
    out_ready = '0;

    // 5: out-of-range on the 6-slot variant (idx 7 and idx 6)
    w6_in_valid = 3'b011;
    in_idx      = idx3(7, 6, 0);
    in_data     = {4'h0, 4'h3, 4'h4};
    #1;
    chk("oor_ready", 64'(w6_ready[1:0]), 64'h3);
    chk("oor_err_pre", 64'(w6_err), 64'h0);
    tick();
    w6_in_valid = '0;
    chk("oor_err_set", 64'(w6_err), 64'h1);
    chk("oor_no_valid", 64'(w6_valid), 64'h0);
    tick();
    tick();
    chk("oor_err_sticky", 64'(w6_err), 64'h1);
    chk("oor_l2h_err_clear", 64'(l2h_err), 64'h0);

    // 6: reset in the middle of stalled traffic
    in_valid = 3'b011;
    in_idx   = idx3(2, 5, 0);
    in_data  = {4'h0, 4'h7, 4'h6};
    tick();
    #1;
    chk("mid_ready_stall", 64'(l2h_ready[1:0]), 64'h0);
    chk("mid_valid_full", 64'(l2h_valid), 64'h24);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_valid", 64'(l2h_valid), 64'h0);
    chk("mid_rst_data",  64'(l2h_data),  64'h0);
    chk("mid_rst_w6_err", 64'(w6_err),   64'h0);
    in_valid = '0;
    rst_n = 1'b1;
    tick();
    chk("post_rst_valid", 64'(l2h_valid), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
